icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped, read-only instruction cache with line refill and uncached single-word reads
// Hits answer one cycle after accept and can pipeline one request per cycle; misses go through MISS/REFILL/RESP.
module icache #(
  parameter int TAG_W    = 20,
  parameter int INDEX_W  = 7,
  parameter int OFFSET_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_cache_valid,
  input  logic                inst_cache_uncache,
  input  logic [TAG_W-1:0]    inst_cache_tag,
  input  logic [INDEX_W-1:0]  inst_cache_index,
  input  logic [OFFSET_W-1:0] inst_cache_offset,
  output logic                inst_cache_addr_ok,
  output logic                inst_cache_data_ok,
  output logic [31:0]         inst_cache_rdata,
  output logic                rd_req,
  output logic [2:0]          rd_type,
  output logic [31:0]         rd_addr,
  input  logic                rd_rdy,
  input  logic                ret_valid,
  input  logic                ret_last,
  input  logic [31:0]         ret_data
);

  localparam int SETS   = 1 << INDEX_W;
  localparam int WORD_W = OFFSET_W - 2;
  localparam int WORDS  = 1 << WORD_W;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS, S_REFILL, S_RESP} state_t;

  state_t r_state;
  state_t w_next;

  logic [TAG_W-1:0]   r_tag;
  logic [INDEX_W-1:0] r_index;
  logic [WORD_W-1:0]  r_word;
  logic               r_uncache;
  logic [WORD_W-1:0]  r_cnt;
  logic [31:0]        r_miss_word;
  logic [31:0]        r_rdata;

  logic [SETS-1:0]    r_valid;
  logic [TAG_W-1:0]   r_tags [SETS];
  logic [31:0]        r_data [SETS*WORDS];

  logic        w_hit;
  logic [31:0] w_hit_word;
  logic        w_accept;
  logic        w_beat;
  logic        w_beat_done;
  logic        w_unused_offset;

  // Byte lanes within a word are irrelevant for 32-bit instruction fetch.
  assign w_unused_offset = ^inst_cache_offset[1:0];

  assign w_hit       = (r_state == S_LOOKUP) & ~r_uncache & r_valid[r_index]
                       & (r_tags[r_index] == r_tag);
  assign w_hit_word  = r_data[{r_index, r_word}];
  assign w_accept    = inst_cache_valid & inst_cache_addr_ok;
  assign w_beat      = (r_state == S_REFILL) & ret_valid;
  assign w_beat_done = w_beat & ret_last;

  assign rd_type = r_uncache ? 3'b010 : 3'b100;
  assign rd_addr = r_uncache ? {r_tag, r_index, r_word, 2'b00}
                             : {r_tag, r_index, {OFFSET_W{1'b0}}};

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next             = r_state;
    inst_cache_addr_ok = 1'b0;
    inst_cache_data_ok = 1'b0;
    inst_cache_rdata   = r_rdata;
    rd_req             = 1'b0;
    case (r_state)
      S_IDLE: begin
        inst_cache_addr_ok = 1'b1;
        if (inst_cache_valid) w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (w_hit) begin
          inst_cache_addr_ok = 1'b1;
          inst_cache_data_ok = 1'b1;
          inst_cache_rdata   = w_hit_word;
          w_next             = inst_cache_valid ? S_LOOKUP : S_IDLE;
        end else begin
          w_next = S_MISS;
        end
      end
      S_MISS: begin
        rd_req = 1'b1;
        if (rd_rdy) w_next = S_REFILL;
      end
      S_REFILL: begin
        if (w_beat_done) w_next = S_RESP;
      end
      S_RESP: begin
        inst_cache_data_ok = 1'b1;
        inst_cache_rdata   = r_miss_word;
        w_next             = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= '0;
      r_cnt       <= '0;
      r_miss_word <= '0;
      r_rdata     <= '0;
      r_tag       <= '0;
      r_index     <= '0;
      r_word      <= '0;
      r_uncache   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tag     <= inst_cache_tag;
        r_index   <= inst_cache_index;
        r_word    <= inst_cache_offset[OFFSET_W-1:2];
        r_uncache <= inst_cache_uncache;
      end
      if (r_state == S_MISS) r_cnt <= '0;
      if (w_beat) begin
        if (!r_uncache) r_cnt <= r_cnt + 1'b1;
        // Uncached reads return exactly the requested word, cached ones the whole line.
        if (r_uncache || (r_cnt == r_word)) r_miss_word <= ret_data;
        if (ret_last && !r_uncache) r_valid[r_index] <= 1'b1;
      end
      if (inst_cache_data_ok) r_rdata <= inst_cache_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_beat && !r_uncache) begin
      r_data[{r_index, r_cnt}] <= ret_data;
      if (ret_last) r_tags[r_index] <= r_tag;
    end
  end

endmodule
